// File: rtl/rect_index_proposer_pkg.sv
// Shared types and constants for the rectangle-loop swap path
// (index proposer and rectangle-loop consumer).
package rect_loop_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAW_R0 = 3'd1,
        DRAW_R1 = 3'd2,
        DRAW_C0 = 3'd3,
        DRAW_C1 = 3'd4,
        OFFER   = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    localparam int RECT_IDX_W = 8;

    typedef struct packed {
        logic [RECT_IDX_W-1:0] r0;
        logic [RECT_IDX_W-1:0] c0;
        logic [RECT_IDX_W-1:0] r1;
        logic [RECT_IDX_W-1:0] c1;
    } rect_idx_t;

endpackage

// File: rtl/rect_index_proposer_lfsr.sv
// Right-shifting Galois LFSR with synchronous reset to SEED, a load port
// and a step enable; load wins over step.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] step_s;

    // Next LFSR value: shift right, fold taps in when a one falls out.
    always_comb begin
        step_s = {1'b0, state_r[WIDTH-1:1]};
        if (state_r[0]) begin
            step_s = {1'b0, state_r[WIDTH-1:1]} ^ TAPS;
        end else begin
            step_s = {1'b0, state_r[WIDTH-1:1]};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= SEED;
        end else if (load) begin
            state_r <= load_val;
        end else if (en) begin
            state_r <= step_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign q = state_r;

endmodule

// File: rtl/rect_index_proposer.sv
// Proposes random rectangle corners (r0,c0,r1,c1), r0!=r1 and c0!=c1, by
// rejection sampling an LFSR, and offers each over valid/ready in bursts.
module rect_index_proposer
    import rect_loop_pkg::*;
#(
    parameter int                MATRIX_ROW = 2,
    parameter int                MATRIX_COL = 2,
    parameter int                ITERATION  = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
    localparam int               ROW_W      = (MATRIX_ROW > 2) ? $clog2(MATRIX_ROW) : 1,
    localparam int               COL_W      = (MATRIX_COL > 2) ? $clog2(MATRIX_COL) : 1,
    localparam int               CNT_W      = $clog2(ITERATION + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [ROW_W-1:0]  r0,
    output logic [COL_W-1:0]  c0,
    output logic [ROW_W-1:0]  r1,
    output logic [COL_W-1:0]  c1,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done
);

    if (MATRIX_ROW < 2) begin : g_bad_row
        $error("rect_index_proposer: MATRIX_ROW must be >= 2");
    end
    if (MATRIX_COL < 2) begin : g_bad_col
        $error("rect_index_proposer: MATRIX_COL must be >= 2");
    end
    if (ITERATION < 1) begin : g_bad_iter
        $error("rect_index_proposer: ITERATION must be >= 1");
    end
    if ((LFSR_W < ROW_W) || (LFSR_W < COL_W)) begin : g_bad_lfsr_w
        $error("rect_index_proposer: LFSR_W narrower than an index");
    end
    if (SEED == {LFSR_W{1'b0}}) begin : g_bad_seed
        $error("rect_index_proposer: SEED must be nonzero");
    end

    localparam logic [ROW_W:0]   ROW_LIM  = (ROW_W + 1)'(MATRIX_ROW);
    localparam logic [COL_W:0]   COL_LIM  = (COL_W + 1)'(MATRIX_COL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATION);

    state_t            state_r;
    state_t            next_state_s;
    logic [LFSR_W-1:0] lfsr_q_s;
    logic [LFSR_W-1:0] seed_val_s;
    logic              lfsr_en_s;
    logic              lfsr_load_s;
    logic              accept_s;
    logic [ROW_W-1:0]  row_cand_s;
    logic [COL_W-1:0]  col_cand_s;
    logic              row_in_range_s;
    logic              col_in_range_s;
    logic [CNT_W-1:0]  count_inc_s;
    logic              unused_lfsr_s;

    logic [ROW_W-1:0]  r0_r;
    logic [COL_W-1:0]  c0_r;
    logic [ROW_W-1:0]  r1_r;
    logic [COL_W-1:0]  c1_r;
    logic [CNT_W-1:0]  count_r;
    logic              idx_valid_r;
    logic              busy_r;
    logic              done_r;

    // A zero seed would lock the LFSR, so it falls back to SEED.
    assign seed_val_s = (seed_in == {LFSR_W{1'b0}}) ? SEED : seed_in;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_W'(LFSR_TAP_MASK)),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (lfsr_en_s),
        .load     (lfsr_load_s),
        .load_val (seed_val_s),
        .q        (lfsr_q_s)
    );

    assign row_cand_s     = lfsr_q_s[ROW_W-1:0];
    assign col_cand_s     = lfsr_q_s[COL_W-1:0];
    assign row_in_range_s = ({1'b0, row_cand_s} < ROW_LIM);
    assign col_in_range_s = ({1'b0, col_cand_s} < COL_LIM);
    assign count_inc_s    = count_r + CNT_W'(1);
    assign unused_lfsr_s  = ^lfsr_q_s;

    // Next-state logic; the LFSR steps on every cycle spent drawing.
    always_comb begin
        next_state_s = state_r;
        lfsr_en_s    = 1'b0;
        lfsr_load_s  = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                lfsr_load_s = seed_load;
                if (start) begin
                    next_state_s = DRAW_R0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAW_R0: begin
                lfsr_en_s    = 1'b1;
                accept_s     = row_in_range_s;
                next_state_s = accept_s ? DRAW_R1 : DRAW_R0;
            end
            DRAW_R1: begin
                lfsr_en_s    = 1'b1;
                accept_s     = row_in_range_s && (row_cand_s != r0_r);
                next_state_s = accept_s ? DRAW_C0 : DRAW_R1;
            end
            DRAW_C0: begin
                lfsr_en_s    = 1'b1;
                accept_s     = col_in_range_s;
                next_state_s = accept_s ? DRAW_C1 : DRAW_C0;
            end
            DRAW_C1: begin
                lfsr_en_s    = 1'b1;
                accept_s     = col_in_range_s && (col_cand_s != c0_r);
                next_state_s = accept_s ? OFFER : DRAW_C1;
            end
            OFFER: begin
                if (idx_ready) begin
                    next_state_s = (count_inc_s == CNT_LAST) ? DONE : DRAW_R0;
                end else begin
                    next_state_s = OFFER;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, burst counter and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            idx_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            idx_valid_r <= (next_state_s == OFFER);
            busy_r      <= (next_state_s != IDLE);
            done_r      <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        count_r <= {CNT_W{1'b0}};
                    end else begin
                        count_r <= count_r;
                    end
                end
                OFFER: begin
                    if (idx_ready) begin
                        count_r <= count_inc_s;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Corner registers capture accepted candidates and otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_r <= {ROW_W{1'b0}};
            c0_r <= {COL_W{1'b0}};
            r1_r <= {ROW_W{1'b0}};
            c1_r <= {COL_W{1'b0}};
        end else if (accept_s) begin
            case (state_r)
                DRAW_R0: r0_r <= row_cand_s;
                DRAW_R1: r1_r <= row_cand_s;
                DRAW_C0: c0_r <= col_cand_s;
                DRAW_C1: c1_r <= col_cand_s;
                default: begin
                    r0_r <= r0_r;
                end
            endcase
        end else begin
            r0_r <= r0_r;
            c0_r <= c0_r;
            r1_r <= r1_r;
            c1_r <= c1_r;
        end
    end

    assign idx_valid = idx_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign count     = count_r;
    assign r0        = r0_r;
    assign c0        = c0_r;
    assign r1        = r1_r;
    assign c1        = c1_r;

endmodule

// File: doc/rect_index_proposer.md
Name: rect_index_proposer

Overview:
- Initiator side of the rectangle-loop swap path. Generates pseudo-random rectangle corner tuples (r0, c0, r1, c1) with r0 != r1 and c0 != c1, all in range for a MATRIX_ROW x MATRIX_COL binary matrix.
- Offers each tuple to the rectangle-loop consumer over a valid/ready handshake.
- Runs a burst of ITERATION proposals per start pulse.

Parameters:
- MATRIX_ROW, 2, matrix row count; must be >= 2 (elaboration error otherwise).
- MATRIX_COL, 2, matrix column count; must be >= 2 (elaboration error otherwise).
- ITERATION, 8, tuples per burst; must be >= 1.
- LFSR_W, 16, LFSR width; must be >= max(ROW_W, COL_W).
- SEED, 16'hACE1, reset/default LFSR state; must be nonzero.
- Derived: ROW_W = max(1, $clog2(MATRIX_ROW)); COL_W = max(1, $clog2(MATRIX_COL)); CNT_W = $clog2(ITERATION+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin burst; sampled only in IDLE
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE
- seed_in  in  LFSR_W  seed value
- idx_valid  out  1  tuple offered
- idx_ready  in  1  consumer accepts tuple
- r0  out  ROW_W  first row
- c0  out  COL_W  first column
- r1  out  ROW_W  second row
- c1  out  COL_W  second column
- count  out  CNT_W  tuples accepted in current burst
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, LFSR=SEED, idx_valid=0, r0=c0=r1=c1=0, count=0, busy=0, done=0. Reset mid-burst abandons the burst; idx_valid is low after that edge; no partial tuple survives.
- LFSR: Galois, 16-bit polynomial x^16+x^14+x^13+x^11+1 (right-shift, tap mask 16'hB400). Steps exactly once per cycle in DRAW_* states only; holds otherwise.
- Seed load: in IDLE, seed_load=1 loads seed_in. seed_in==0 loads SEED instead (no lockup). If start and seed_load are high together, the seed loads first and the burst starts on the same edge using the new seed.
- Candidate values: row candidate = LFSR[ROW_W-1:0]; column candidate = LFSR[COL_W-1:0], taken from the current (pre-step) state.
- FSM states and transitions:
  - IDLE: start=1 -> count=0, go to DRAW_R0.
  - DRAW_R0: candidate < MATRIX_ROW -> latch r0, go to DRAW_R1; else stay (rejection).
  - DRAW_R1: candidate < MATRIX_ROW and != r0 -> latch r1, go to DRAW_C0; else stay.
  - DRAW_C0: candidate < MATRIX_COL -> latch c0, go to DRAW_C1; else stay.
  - DRAW_C1: candidate < MATRIX_COL and != c0 -> latch c1, go to OFFER; else stay.
  - OFFER: idx_valid=1. r0/c0/r1/c1 stay stable until handshake (idx_valid & idx_ready at posedge). On handshake: count+1; if the new count == ITERATION go to DONE, else go to DRAW_R0. idx_valid drops on the handshake edge; there are no back-to-back offers.
  - DONE: done=1 for one cycle, then IDLE. count holds its final value until the next start.
- Latency: minimum 4 cycles from entering DRAW_R0 to idx_valid=1, with 1 extra cycle per rejected candidate. No upper bound, but termination is guaranteed because the LFSR is maximal-length.
- start outside IDLE: ignored, no effect on count or state. seed_load outside IDLE: ignored.
- Tuple outputs hold their last values in IDLE and DONE.

Decomposition:
- Package rect_loop_pkg holds:
  - the FSM state enum (IDLE, DRAW_R0, DRAW_R1, DRAW_C0, DRAW_C1, OFFER, DONE);
  - the LFSR tap-mask constant;
  - a packed struct rect_idx_t {r0, c0, r1, c1}, shared with the rectangle-loop consumer.
- Sub-module lfsr_galois (params WIDTH, TAPS, SEED; ports clk, rst_n, en, load, load_val, q) holds the LFSR state; the FSM lives in rect_index_proposer.

Test Plan:
- Reset with default params -> idx_valid=0, busy=0, count=0, done=0, all tuple fields 0. After start with idx_ready tied to 1 -> first idx_valid no earlier than 4 cycles later.
- 2x2 matrix, ITERATION=8, idx_ready=1, start pulse -> exactly 8 handshakes, each tuple a permutation ({0,1},{0,1}) with r0!=r1 and c0!=c1. done pulses once after the 8th. count=8, busy=0 afterward.
- MATRIX_ROW=3, MATRIX_COL=5, 200-tuple burst checked against a bench LFSR reference model -> bit-exact match, rows never 3, columns never >=5.
- Backpressure: hold idx_ready=0 for 20 cycles in OFFER -> idx_valid stays 1, fields and LFSR unchanged; idx_ready=1 -> single handshake, count increments by 1.
- seed_load with seed_in=16'h0000 in IDLE, then a burst -> tuple sequence identical to the post-reset burst. seed_in=16'h1234 -> a different, deterministic sequence.
- rst_n=0 asserted while in OFFER mid-burst -> idx_valid=0, busy=0, count=0 after that edge. A start pulse during busy -> ignored, count unchanged.
